// File: rtl/fixed_point_division_pkg.sv
// rtl/fixed_point_division_pkg.sv - shared constants and FSM state type for the fixed-point divider
// Holds the default operand format, the iteration count and the controller state encoding.
package fixed_point_division_pkg;

  localparam int WIDTH = 10;             // operand and quotient width
  localparam int FRAC  = 4;              // fractional bits (unsigned Q6.4)
  localparam int ITER  = WIDTH + FRAC;   // iterations = extended dividend width
  localparam int CNT_W = $clog2(ITER);   // iteration counter width

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    INIT    = 2'd1,
    COMPUTE = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/fixed_point_division_if.sv
// rtl/fixed_point_division_if.sv - operand-load handshake and result bus of the divider
// master: drives loading_done, start, ld_a, ld_b, A, B; observes Q, ov, gT, dvz, CO_CNT.
// slave : the divider side of the same signals.
interface fixed_point_division_if;
  import fixed_point_division_pkg::*;

  logic             loading_done;
  logic             start;
  logic             ld_a;
  logic             ld_b;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Q;
  logic             ov;
  logic             gT;
  logic             dvz;
  logic             CO_CNT;

  modport master (
    output loading_done, start, ld_a, ld_b, A, B,
    input  Q, ov, gT, dvz, CO_CNT
  );

  modport slave (
    input  loading_done, start, ld_a, ld_b, A, B,
    output Q, ov, gT, dvz, CO_CNT
  );

endinterface

// File: rtl/fpd_datapath.sv
// rtl/fpd_datapath.sv - restoring shift/subtract datapath of the fixed-point divider
// Ports: clk, rst (sync, active-high); ld_a/ld_b load enables; init clears the
// iteration state; computing advances one iteration per cycle; a_in/b_in operands;
// gt comparator status; last marks the final iteration; b_zero divisor is zero;
// qs_next is the quotient shift register including the bit decided this cycle.
module fpd_datapath
  import fixed_point_division_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_a,
  input  logic             ld_b,
  input  logic             init,
  input  logic             computing,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             gt,
  output logic             last,
  output logic             b_zero,
  output logic [ITER-1:0]  qs_next
);

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [ITER-1:0]  n_reg;
  logic [WIDTH:0]   r_reg;
  logic [ITER-1:0]  qs_reg;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   trial;
  logic             trial_ge;

  // The remainder is always below the divisor, so its low WIDTH bits plus the
  // next dividend bit form the full trial value.
  assign trial    = {r_reg[WIDTH-1:0], n_reg[ITER-1]};
  assign trial_ge = (trial >= {1'b0, b_reg});
  assign gt       = computing & trial_ge;
  assign qs_next  = {qs_reg[ITER-2:0], trial_ge};
  assign last     = (cnt == CNT_W'(ITER - 1));
  assign b_zero   = (b_reg == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg  <= '0;
      b_reg  <= '0;
      n_reg  <= '0;
      r_reg  <= '0;
      qs_reg <= '0;
      cnt    <= '0;
    end else begin
      if (ld_a) a_reg <= a_in;
      if (ld_b) b_reg <= b_in;
      if (init) begin
        n_reg  <= {a_reg, {FRAC{1'b0}}};
        r_reg  <= '0;
        qs_reg <= '0;
        cnt    <= '0;
      end else if (computing) begin
        n_reg  <= {n_reg[ITER-2:0], 1'b0};
        r_reg  <= trial_ge ? (trial - {1'b0, b_reg}) : trial;
        qs_reg <= qs_next;
        cnt    <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fixed_point_division.sv
// rtl/fixed_point_division.sv - sequential unsigned Q6.4 divider, FSM controller and result registers
// Ports: clk, rst (sync, active-high); bus (slave) carries loading_done, start,
// ld_a, ld_b, A, B in and Q, ov, gT, dvz, CO_CNT out.
module fixed_point_division
  import fixed_point_division_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  fixed_point_division_if.slave bus
);

  state_t           state;
  logic [WIDTH-1:0] q_r;
  logic             ov_r;
  logic             dvz_r;
  logic             co_r;

  logic             gt;
  logic             last;
  logic             b_zero;
  logic [ITER-1:0]  qs_next;

  fpd_datapath u_datapath (
    .clk       (clk),
    .rst       (rst),
    .ld_a      (bus.ld_a & (state == LOAD)),
    .ld_b      (bus.ld_b & (state == LOAD)),
    .init      (state == INIT),
    .computing (state == COMPUTE),
    .a_in      (bus.A),
    .b_in      (bus.B),
    .gt        (gt),
    .last      (last),
    .b_zero    (b_zero),
    .qs_next   (qs_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
      q_r   <= '0;
      ov_r  <= 1'b0;
      dvz_r <= 1'b0;
      co_r  <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (bus.loading_done) state <= INIT;
        end
        INIT: begin
          if (b_zero) begin
            q_r   <= '1;
            ov_r  <= 1'b1;
            dvz_r <= 1'b1;
            co_r  <= 1'b1;
            state <= DONE;
          end else begin
            state <= COMPUTE;
          end
        end
        COMPUTE: begin
          // Result is taken from qs_next so the last decided bit is included.
          if (last) begin
            co_r  <= 1'b1;
            state <= DONE;
            if (|qs_next[ITER-1:WIDTH]) begin
              q_r  <= '1;
              ov_r <= 1'b1;
            end else begin
              q_r  <= qs_next[WIDTH-1:0];
              ov_r <= 1'b0;
            end
          end
        end
        DONE: begin
          // Q is deliberately kept so the last result stays readable.
          if (bus.start) begin
            co_r  <= 1'b0;
            ov_r  <= 1'b0;
            dvz_r <= 1'b0;
            state <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign bus.Q      = q_r;
  assign bus.ov     = ov_r;
  assign bus.dvz    = dvz_r;
  assign bus.CO_CNT = co_r;
  assign bus.gT     = gt;

endmodule

// File: tb/tb_fixed_point_division.sv
// tb/tb_fixed_point_division.sv - scoreboard testbench for fixed_point_division
module tb_fixed_point_division;
  import fixed_point_division_pkg::*;

  typedef struct {
    int q;
    int ov;
    int dvz;
    int full;
    int issue;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_bad;
  int   last_q;
  exp_t sb[$];

  fixed_point_division_if bus ();

  fixed_point_division dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: quotient = floor(A * 2^FRAC / B), saturating at the WIDTH-bit maximum.
  function automatic exp_t model(input int a, input int b, input int issue);
    exp_t e;
    int   maxq;
    maxq    = (1 << WIDTH) - 1;
    e.issue = issue;
    if (b == 0) begin
      e.q = maxq; e.ov = 1; e.dvz = 1; e.full = 0;
    end else begin
      e.full = (a * (1 << FRAC)) / b;
      e.dvz  = 0;
      e.ov   = (e.full > maxq) ? 1 : 0;
      e.q    = e.ov ? maxq : e.full;
    end
    return e;
  endfunction

  // Monitor: on each rising CO_CNT pop and compare; the gT history of the
  // preceding 14 cycles must spell the full quotient MSB-first.
  initial begin
    logic           prev_co;
    logic [ITER-1:0] hist;
    exp_t           e;
    prev_co = 1'b0;
    hist    = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_co = 1'b0;
        hist    = '0;
      end else begin
        if (bus.CO_CNT && !prev_co) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got CO_CNT=1 expected no result pending");
          end else begin
            e = sb.pop_front();
            check("Q", int'(bus.Q), e.q);
            check("ov", int'(bus.ov), e.ov);
            check("dvz", int'(bus.dvz), e.dvz);
            check("latency", cyc - e.issue, e.dvz ? 2 : ITER + 2);
            if (e.dvz == 0) check("gT_trace", int'(hist), e.full);
          end
        end
        if (bus.CO_CNT) check("gT_in_done", int'(bus.gT), 0);
        hist    = {hist[ITER-2:0], bus.gT};
        prev_co = bus.CO_CNT;
      end
    end
  end

  task automatic issue(input int a, input int b, input bit expect_result);
    exp_t e;
    @(negedge clk);
    bus.A            = WIDTH'(a);
    bus.B            = WIDTH'(b);
    bus.ld_a         = 1'b1;
    bus.ld_b         = 1'b1;
    bus.loading_done = 1'b1;
    e = model(a, b, cyc);
    last_q = e.q;
    if (expect_result) sb.push_back(e);
    @(negedge clk);
    bus.loading_done = 1'b0;
    bus.ld_a         = 1'b0;
    bus.ld_b         = 1'b0;
  endtask

  // Waits for CO_CNT while driving loads and start that must be ignored.
  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bus.CO_CNT) begin
        seen = 1'b1;
      end else begin
        bus.A     = WIDTH'($urandom);
        bus.B     = WIDTH'($urandom);
        bus.ld_a  = 1'($urandom);
        bus.ld_b  = 1'($urandom);
        bus.start = 1'($urandom);
        @(negedge clk);
      end
    end
    bus.ld_a  = 1'b0;
    bus.ld_b  = 1'b0;
    bus.start = 1'b0;
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got CO_CNT=0 expected 1 within 40 cycles");
    end
  endtask

  task automatic release_done();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("co_after_start", int'(bus.CO_CNT), 0);
    check("ov_after_start", int'(bus.ov), 0);
    check("dvz_after_start", int'(bus.dvz), 0);
    check("q_hold_after_start", int'(bus.Q), last_q);
  endtask

  task automatic run_op(input int a, input int b);
    issue(a, b, 1'b1);
    wait_done();
    release_done();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_Q"}, int'(bus.Q), 0);
    check({tag, "_ov"}, int'(bus.ov), 0);
    check({tag, "_dvz"}, int'(bus.dvz), 0);
    check({tag, "_CO_CNT"}, int'(bus.CO_CNT), 0);
    check({tag, "_gT"}, int'(bus.gT), 0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    last_q = 0;
    rst = 1'b1;
    bus.loading_done = 1'b0;
    bus.start = 1'b0;
    bus.ld_a = 1'b0;
    bus.ld_b = 1'b0;
    bus.A = '0;
    bus.B = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("reset");

    run_op(110, 3);
    run_op(8, 32);
    run_op(1023, 1);
    run_op(int'($urandom_range(0, 1023)), 0);
    run_op(16, 16);

    // Abort a division in flight.
    issue(110, 3, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("midreset");
    repeat (20) @(negedge clk);
    check("midreset_idle_CO_CNT", int'(bus.CO_CNT), 0);
    run_op(110, 3);

    for (int i = 0; i < 25; i++) begin
      int a;
      int b;
      a = int'($urandom_range(0, 1023));
      b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 1023));
      if ($urandom_range(0, 3) == 0) b = int'($urandom_range(1, 15));
      run_op(a, b);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fixed_point_division.md
# fixed_point_division

Sequential unsigned fixed-point divider: computes Q = A / B for 10-bit operands sharing a common fixed-point format, using a restoring shift/subtract datapath driven by a small FSM. It is a standalone arithmetic block with an operand-load handshake. Its iteration-counter carry-out (CO_CNT) doubles as the done strobe. It also exports overflow, divide-by-zero and comparator status.

## Interface
- WIDTH, 10: operand and quotient width.
- FRAC, 4: fractional bits in A, B and Q (unsigned Q6.4).
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous and active-high.
- loading_done  in  1  operands are loaded; in LOAD, start the division.
- start  in  1  in DONE, return to LOAD for a new operation.
- ld_a  in  1  load A into the dividend register (LOAD state only).
- ld_b  in  1  load B into the divisor register (LOAD state only).
- A  in  WIDTH  dividend.
- B  in  WIDTH  divisor.
- Q  out  WIDTH  quotient (registered).
- ov  out  1  quotient overflow (registered).
- gT  out  1  comparator: partial remainder ≥ divisor; 0 outside COMPUTE.
- dvz  out  1  divide by zero (registered).
- CO_CNT  out  1  iteration counter terminal/carry-out = done; held in DONE.

## Operation
- States: LOAD, INIT, COMPUTE, DONE. Reset → LOAD.
- **LOAD**
  - ld_a / ld_b each load their register on the clock edge.
  - loading_done=1 → INIT. Loads on that same edge are used.
- **INIT**
  - Form extended dividend N = {A_reg, FRAC zeros} (WIDTH+FRAC = 14 bits).
  - Clear remainder R (WIDTH+1 bits), quotient shift register QS (14 bits) and counter.
  - If B_reg == 0: Q=all ones, dvz=1, ov=1 → DONE.
  - Else → COMPUTE.
- **COMPUTE** (one iteration per cycle, 14 iterations, N MSB-first)
  - T = {R[WIDTH-1:0], next N bit}.
  - gT = (T ≥ B_reg).
  - If gT: R = T − B_reg and shift 1 into QS; else R = T and shift 0.
  - Counter increments; its carry-out on the 14th iteration → DONE.
- **Result on entering DONE**
  - If QS[13:WIDTH] ≠ 0: ov=1 and Q saturates to all ones.
  - Else Q = QS[WIDTH-1:0], ov=0.
  - Remainder is discarded (truncation toward zero).
- **DONE**
  - CO_CNT=1, outputs held.
  - start=1 → LOAD: CO_CNT, ov, dvz clear; Q holds its last value.
- start outside DONE is ignored. ld_a/ld_b outside LOAD are ignored.

## Timing
- Reset values:
  - Q=0, ov=0, dvz=0, CO_CNT=0, gT=0.
  - Operand registers, R, QS and counter all 0.
- Reset asserted in any state: next edge → LOAD with reset values; any computation in flight is aborted.
- loading_done sampled at edge k:
  - INIT executes at edge k+1.
  - COMPUTE iterations at edges k+2..k+15.
  - Q, ov, dvz, CO_CNT valid after edge k+15.
- Divide by zero: results valid after edge k+1.
- gT is combinational from R, N and B_reg; valid only in COMPUTE.
- All other outputs are registered.

## Structure
- Shared package holds:
  - WIDTH/FRAC defaults.
  - State enum {LOAD, INIT, COMPUTE, DONE}.
  - ITER = WIDTH+FRAC constant.
- One natural split:
  - fpd_datapath: registers, shifter, comparator/subtractor, counter.
  - The top module holds the FSM controller.

## Test plan
- A=0001101110 (6.875), B=0000000011 (0.1875), loading_done after reset → CO_CNT=1 after 15 cycles, Q=1001001010 (36.625), ov=0, dvz=0.
- A=0000001000 (0.5), B=0000100000 (2.0) → Q=0000000100 (0.25), ov=0.
- A=1111111111, B=0000000001 → ov=1, Q=1111111111, dvz=0.
- B=0, A=any → after INIT: dvz=1, ov=1, Q=1111111111, CO_CNT=1.
- Reset asserted mid-COMPUTE → all outputs 0 next cycle, state LOAD. Re-run of the first case gives the same result.
- In DONE, pulse start, load A=0000010000 (1.0), B=0000010000 → CO_CNT drops, then Q=0000010000 after 15 cycles.
